// File: rtl/ex_pkg.sv
// Shared op codes, FSM states and forwarding encodings for the execute stage.
// EX_DIV_EN adds DIVU/REMU to the multi-cycle engine.
package ex_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] OP_ADD   = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB   = 4'd1;
  localparam logic [OP_W-1:0] OP_AND   = 4'd2;
  localparam logic [OP_W-1:0] OP_OR    = 4'd3;
  localparam logic [OP_W-1:0] OP_XOR   = 4'd4;
  localparam logic [OP_W-1:0] OP_SLL   = 4'd5;
  localparam logic [OP_W-1:0] OP_SRL   = 4'd6;
  localparam logic [OP_W-1:0] OP_SRA   = 4'd7;
  localparam logic [OP_W-1:0] OP_MUL   = 4'd8;
  localparam logic [OP_W-1:0] OP_MULHU = 4'd9;
  localparam logic [OP_W-1:0] OP_DIVU  = 4'd10;
  localparam logic [OP_W-1:0] OP_REMU  = 4'd11;

  localparam logic [1:0] FWD_REG  = 2'd0;
  localparam logic [1:0] FWD_MEM  = 2'd1;
  localparam logic [1:0] FWD_WB   = 2'd2;
  localparam logic [1:0] FWD_REG3 = 2'd3;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } ccodes_t;

  function automatic logic is_div(input logic [OP_W-1:0] op);
    return (op == OP_DIVU) || (op == OP_REMU);
  endfunction

  function automatic logic is_multicycle(input logic [OP_W-1:0] op);
`ifdef EX_DIV_EN
    return (op == OP_MUL) || (op == OP_MULHU) || is_div(op);
`else
    return (op == OP_MUL) || (op == OP_MULHU);
`endif
  endfunction

endpackage

// File: rtl/ex_muldiv_iter.sv
// Iterative one-bit-per-cycle multiply (shift-add) and, with EX_DIV_EN,
// restoring divide; owns the IDLE/RUN/DONE sequencing and operand latches.
module ex_muldiv_iter
  import ex_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  input  logic             abort,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy_c,
  output logic             done_c,
  output logic [WIDTH-1:0] result_c
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  md_state_e          state;
  md_state_e          state_next;
  logic               load;
  logic               step;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   opb_q;
  logic [OP_W-1:0]    op_q;
  logic [WIDTH:0]     mul_sum;
`ifdef EX_DIV_EN
  logic [WIDTH:0]     div_part;
  logic [WIDTH:0]     div_diff;
  logic               q_bit;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= MD_IDLE;
    else       state <= state_next;
  end

  // Sequencing: stays in DONE while downstream is stalled so the result is not lost.
  always_comb begin
    state_next = state;
    busy_c     = 1'b0;
    done_c     = 1'b0;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      MD_IDLE: begin
        busy_c = start;
        if (start && !abort) begin
          load       = 1'b1;
          state_next = MD_RUN;
        end
      end
      MD_RUN: begin
        busy_c = 1'b1;
        step   = 1'b1;
        if (abort)            state_next = MD_IDLE;
        else if (cnt == '0)   state_next = MD_DONE;
      end
      MD_DONE: begin
        busy_c = stall;
        done_c = 1'b1;
        if (abort || !stall) state_next = MD_IDLE;
      end
      default: state_next = MD_IDLE;
    endcase
  end

  // acc = {high/remainder, low/quotient}; both engines retire one bit per step.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb_q} : '0);
    acc_next = {mul_sum, acc[WIDTH-1:1]};
`ifdef EX_DIV_EN
    div_part = acc[2*WIDTH-1:WIDTH-1];
    div_diff = div_part - {1'b0, opb_q};
    q_bit    = (div_part >= {1'b0, opb_q});
    if (is_div(op_q)) begin
      acc_next = {(q_bit ? div_diff[WIDTH-1:0] : div_part[WIDTH-1:0]),
                  acc[WIDTH-2:0], q_bit};
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      acc   <= '0;
      opb_q <= '0;
      op_q  <= OP_ADD;
    end else if (load) begin
      cnt   <= CNT_W'(WIDTH - 1);
      acc   <= {{WIDTH{1'b0}}, opa};
      opb_q <= opb;
      op_q  <= op;
    end else if (step) begin
      cnt   <= cnt - CNT_W'(1);
      acc   <= acc_next;
    end
  end

  assign result_c = ((op_q == OP_MULHU) || (op_q == OP_REMU)) ? acc[2*WIDTH-1:WIDTH]
                                                               : acc[WIDTH-1:0];

endmodule

// File: rtl/ex_stage_mc.sv
// Execute stage: operand forwarding, single-cycle ALU, NZCV register and the
// EX/MA register, with MUL/DIV handed to ex_muldiv_iter (DIV only if EX_DIV_EN).
module ex_stage_mc
  import ex_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned RADDR_W = 5,
  parameter int unsigned WB_W    = 2,
  parameter int unsigned MA_W    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_valid,
  input  logic [OP_W-1:0]    i_op,
  input  logic               i_cc_we,
  input  logic               i_src2_imm,
  input  logic [WIDTH-1:0]   i_rs1,
  input  logic [WIDTH-1:0]   i_rs2,
  input  logic [WIDTH-1:0]   i_imm,
  input  logic [WIDTH-1:0]   i_pc,
  input  logic [1:0]         i_fwd_sel1,
  input  logic [1:0]         i_fwd_sel2,
  input  logic [WIDTH-1:0]   i_fwd_mem,
  input  logic [WIDTH-1:0]   i_fwd_wb,
  input  logic [RADDR_W-1:0] i_rds_addr,
  input  logic [WB_W-1:0]    i_wb_ctrl,
  input  logic [MA_W-1:0]    i_ma_ctrl,
  input  logic               i_stall,
  input  logic               i_flush,
  output logic               o_busy,
  output logic               o_valid,
  output logic [WIDTH-1:0]   o_rslt,
  output logic [WIDTH-1:0]   o_store_data,
  output logic [WIDTH-1:0]   o_pc,
  output logic [RADDR_W-1:0] o_rds_addr,
  output logic [WB_W-1:0]    o_wb_ctrl,
  output logic [MA_W-1:0]    o_ma_ctrl,
  output logic [3:0]         o_ccodes
);

  localparam int unsigned SH_W = $clog2(WIDTH);

  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] rs2_fwd;
  logic [WIDTH-1:0] op2;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [SH_W-1:0]  shamt;
  logic [WIDTH-1:0] alu;
  logic             carry;
  logic             ovf;
  ccodes_t          alu_cc;
  ccodes_t          cc;
  logic             md_start;
  logic             md_done;
  logic [WIDTH-1:0] md_result;
  logic             alu_accept;

  always_comb begin
    op1 = i_rs1;
    case (i_fwd_sel1)
      FWD_MEM: op1 = i_fwd_mem;
      FWD_WB:  op1 = i_fwd_wb;
      default: op1 = i_rs1;
    endcase
    rs2_fwd = i_rs2;
    case (i_fwd_sel2)
      FWD_MEM: rs2_fwd = i_fwd_mem;
      FWD_WB:  rs2_fwd = i_fwd_wb;
      default: rs2_fwd = i_rs2;
    endcase
    op2 = i_src2_imm ? i_imm : rs2_fwd;
  end

  // Single-cycle ALU; illegal and multi-cycle codes fall through to zero.
  always_comb begin
    sum   = {1'b0, op1} + {1'b0, op2};
    diff  = {1'b0, op1} - {1'b0, op2};
    shamt = op2[SH_W-1:0];
    alu   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (i_op)
      OP_ADD: begin
        alu   = sum[WIDTH-1:0];
        carry = sum[WIDTH];
        ovf   = (op1[WIDTH-1] == op2[WIDTH-1]) && (sum[WIDTH-1] != op1[WIDTH-1]);
      end
      OP_SUB: begin
        alu   = diff[WIDTH-1:0];
        carry = ~diff[WIDTH];
        ovf   = (op1[WIDTH-1] != op2[WIDTH-1]) && (diff[WIDTH-1] != op1[WIDTH-1]);
      end
      OP_AND:  alu = op1 & op2;
      OP_OR:   alu = op1 | op2;
      OP_XOR:  alu = op1 ^ op2;
      OP_SLL:  alu = op1 << shamt;
      OP_SRL:  alu = op1 >> shamt;
      OP_SRA:  alu = WIDTH'($signed(op1) >>> shamt);
      default: alu = '0;
    endcase
    alu_cc.n = alu[WIDTH-1];
    alu_cc.z = (alu == '0);
    alu_cc.c = carry;
    alu_cc.v = ovf;
  end

  assign md_start = i_valid && is_multicycle(i_op);

  ex_muldiv_iter #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk      (clk),
    .reset    (reset),
    .start    (md_start),
    .stall    (i_stall),
    .abort    (i_flush),
    .op       (i_op),
    .opa      (op1),
    .opb      (rs2_fwd),
    .busy_c   (o_busy),
    .done_c   (md_done),
    .result_c (md_result)
  );

  assign alu_accept = i_valid && !o_busy && !md_done && !i_stall && !i_flush
                      && !is_multicycle(i_op);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       cc <= '0;
    else if (alu_accept && i_cc_we)  cc <= alu_cc;
  end

  assign o_ccodes = cc;

  // EX/MA register: flush beats stall; bubbles while the engine is busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_valid      <= 1'b0;
      o_rslt       <= '0;
      o_store_data <= '0;
      o_pc         <= '0;
      o_rds_addr   <= '0;
      o_wb_ctrl    <= '0;
      o_ma_ctrl    <= '0;
    end else if (i_flush) begin
      o_valid      <= 1'b0;
    end else if (!i_stall) begin
      if (o_busy) begin
        o_valid      <= 1'b0;
      end else begin
        o_valid      <= md_done ? 1'b1 : i_valid;
        o_rslt       <= md_done ? md_result : alu;
        o_store_data <= rs2_fwd;
        o_pc         <= i_pc;
        o_rds_addr   <= i_rds_addr;
        o_wb_ctrl    <= i_wb_ctrl;
        o_ma_ctrl    <= i_ma_ctrl;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage_mc.sv
// Directed bench for ex_stage_mc: ALU vector table plus multi-cycle sequences
// (latency, stall in DONE, flush in RUN, reset in RUN, optional EX_DIV_EN).
module tb_ex_stage_mc;
  import ex_pkg::*;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned RADDR_W = 5;
  localparam int unsigned WB_W    = 2;
  localparam int unsigned MA_W    = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               i_valid;
  logic [3:0]         i_op;
  logic               i_cc_we;
  logic               i_src2_imm;
  logic [WIDTH-1:0]   i_rs1, i_rs2, i_imm, i_pc;
  logic [1:0]         i_fwd_sel1, i_fwd_sel2;
  logic [WIDTH-1:0]   i_fwd_mem, i_fwd_wb;
  logic [RADDR_W-1:0] i_rds_addr;
  logic [WB_W-1:0]    i_wb_ctrl;
  logic [MA_W-1:0]    i_ma_ctrl;
  logic               i_stall, i_flush;
  logic               o_busy, o_valid;
  logic [WIDTH-1:0]   o_rslt, o_store_data, o_pc;
  logic [RADDR_W-1:0] o_rds_addr;
  logic [WB_W-1:0]    o_wb_ctrl;
  logic [MA_W-1:0]    o_ma_ctrl;
  logic [3:0]         o_ccodes;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_stage_mc #(
    .WIDTH(WIDTH), .RADDR_W(RADDR_W), .WB_W(WB_W), .MA_W(MA_W)
  ) dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_op(i_op), .i_cc_we(i_cc_we),
    .i_src2_imm(i_src2_imm), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_imm(i_imm), .i_pc(i_pc),
    .i_fwd_sel1(i_fwd_sel1), .i_fwd_sel2(i_fwd_sel2), .i_fwd_mem(i_fwd_mem),
    .i_fwd_wb(i_fwd_wb), .i_rds_addr(i_rds_addr), .i_wb_ctrl(i_wb_ctrl),
    .i_ma_ctrl(i_ma_ctrl), .i_stall(i_stall), .i_flush(i_flush), .o_busy(o_busy),
    .o_valid(o_valid), .o_rslt(o_rslt), .o_store_data(o_store_data), .o_pc(o_pc),
    .o_rds_addr(o_rds_addr), .o_wb_ctrl(o_wb_ctrl), .o_ma_ctrl(o_ma_ctrl),
    .o_ccodes(o_ccodes)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rs1, rs2, imm;
    logic        simm;
    logic [1:0]  sel1, sel2;
    logic [31:0] mem, wb;
    logic        cc_we;
    logic [31:0] exp_rslt;
    logic [3:0]  exp_cc;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] rs1, rs2, imm,
                              input logic simm, input logic [1:0] sel1, sel2,
                              input logic [31:0] mem, wb, input logic cc_we,
                              input logic [31:0] exp_rslt, input logic [3:0] exp_cc);
    vec_t r;
    r.op = op; r.rs1 = rs1; r.rs2 = rs2; r.imm = imm; r.simm = simm;
    r.sel1 = sel1; r.sel2 = sel2; r.mem = mem; r.wb = wb; r.cc_we = cc_we;
    r.exp_rslt = exp_rslt; r.exp_cc = exp_cc;
    return r;
  endfunction

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    i_valid = 1'b1; i_op = op; i_rs1 = a; i_rs2 = b; i_imm = '0; i_src2_imm = 1'b0;
    i_fwd_sel1 = 2'd0; i_fwd_sel2 = 2'd0; i_cc_we = 1'b1;
    i_pc = 32'h0000_2000; i_rds_addr = 5'd3; i_wb_ctrl = 2'd1; i_ma_ctrl = 4'd2;
  endtask

  // Runs one multi-cycle op; optionally holds i_stall for nstall cycles in DONE.
  task automatic run_mc(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int nstall);
    int busy_seen;
    int bubbles;
    busy_seen = 0;
    bubbles   = 0;
    drive(op, a, b);
    #1;
    for (int k = 0; k < int'(WIDTH) + 1; k++) begin
      if (o_busy) busy_seen++;
      @(posedge clk); #1;
      if (!o_valid) bubbles++;
      if (k == 0) begin
        i_rs1 = 32'hDEAD_BEEF;
        i_rs2 = 32'h0BAD_F00D;
      end
    end
    chk({name, " busy_cycles"}, 32'(busy_seen), 32'(WIDTH + 1));
    chk({name, " bubbles"}, 32'(bubbles), 32'(WIDTH + 1));
    if (nstall > 0) begin
      i_stall = 1'b1;
      for (int s = 0; s < nstall; s++) begin
        #1;
        chk({name, " busy_in_stall"}, 32'(o_busy), 32'd1);
        @(posedge clk); #1;
        chk({name, " valid_in_stall"}, 32'(o_valid), 32'd0);
      end
      i_stall = 1'b0;
    end
    #1;
    chk({name, " busy_drop"}, 32'(o_busy), 32'd0);
    @(posedge clk); #1;
    chk({name, " valid"}, 32'(o_valid), 32'd1);
    chk({name, " rslt"}, o_rslt, exp);
    i_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t v;
    logic [31:0] exp_st;

    reset = 1'b1; i_valid = 1'b0; i_op = '0; i_cc_we = 1'b0; i_src2_imm = 1'b0;
    i_rs1 = '0; i_rs2 = '0; i_imm = '0; i_pc = '0; i_fwd_sel1 = '0; i_fwd_sel2 = '0;
    i_fwd_mem = '0; i_fwd_wb = '0; i_rds_addr = '0; i_wb_ctrl = '0; i_ma_ctrl = '0;
    i_stall = 1'b0; i_flush = 1'b0;
    #3;
    chk("reset valid", 32'(o_valid), 32'd0);
    chk("reset rslt", o_rslt, 32'd0);
    chk("reset cc", 32'(o_ccodes), 32'd0);
    chk("reset busy", 32'(o_busy), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    //            op      rs1           rs2           imm           si s1    s2    mem      wb    we exp           NZCV
    vecs.push_back(mk(OP_ADD, 32'd0,        32'd7,        32'd0,        0, 2'd1, 2'd0, 32'd100, 32'd0, 1, 32'd107,      4'b0000));
    vecs.push_back(mk(OP_SUB, 32'd3,        32'd5,        32'd0,        0, 2'd0, 2'd0, 32'd0,   32'd0, 1, 32'hFFFFFFFE, 4'b1000));
    vecs.push_back(mk(OP_SUB, 32'd5,        32'd5,        32'd0,        0, 2'd0, 2'd0, 32'd0,   32'd0, 1, 32'd0,        4'b0110));
    vecs.push_back(mk(OP_ADD, 32'hFFFFFFFF, 32'd0,        32'd0,        0, 2'd0, 2'd2, 32'd0,   32'd1, 1, 32'd0,        4'b0110));
    vecs.push_back(mk(OP_ADD, 32'h7FFFFFFF, 32'd1,        32'd0,        0, 2'd0, 2'd0, 32'd0,   32'd0, 1, 32'h80000000, 4'b1001));
    vecs.push_back(mk(OP_SUB, 32'h80000000, 32'd1,        32'd0,        0, 2'd0, 2'd0, 32'd0,   32'd0, 1, 32'h7FFFFFFF, 4'b0011));
    vecs.push_back(mk(OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        0, 2'd0, 2'd0, 32'd0,   32'd0, 1, 32'hF000F000, 4'b1000));
    vecs.push_back(mk(OP_AND, 32'd0,        32'hFFFFFFFF, 32'd0,        0, 2'd0, 2'd0, 32'd0,   32'd0, 0, 32'd0,        4'b1000));
    vecs.push_back(mk(OP_OR,  32'h0F,       32'hF0,       32'd0,        0, 2'd0, 2'd0, 32'd0,   32'd0, 1, 32'hFF,       4'b0000));
    vecs.push_back(mk(OP_XOR, 32'hAAAA5555, 32'h12345678, 32'hFFFF0000, 1, 2'd0, 2'd0, 32'd0,   32'd0, 1, 32'h55555555, 4'b0000));
    vecs.push_back(mk(OP_SLL, 32'd1,        32'd0,        32'd35,       1, 2'd0, 2'd0, 32'd0,   32'd0, 1, 32'd8,        4'b0000));
    vecs.push_back(mk(OP_SRL, 32'h80000000, 32'd31,       32'd0,        0, 2'd0, 2'd0, 32'd0,   32'd0, 1, 32'd1,        4'b0000));
    vecs.push_back(mk(OP_SRA, 32'h80000000, 32'd4,        32'd0,        0, 2'd0, 2'd0, 32'd0,   32'd0, 1, 32'hF8000000, 4'b1000));
    vecs.push_back(mk(4'd12,  32'd5,        32'd6,        32'd0,        0, 2'd0, 2'd0, 32'd0,   32'd0, 1, 32'd0,        4'b0100));
    vecs.push_back(mk(OP_ADD, 32'd10,       32'd20,       32'd0,        0, 2'd3, 2'd0, 32'd999, 32'd0, 1, 32'd30,       4'b0000));
    vecs.push_back(mk(OP_SRA, 32'h7FFFFFF0, 32'd4,        32'd0,        0, 2'd0, 2'd0, 32'd0,   32'd0, 1, 32'h07FFFFFF, 4'b0000));

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      i_valid = 1'b1; i_op = v.op; i_rs1 = v.rs1; i_rs2 = v.rs2; i_imm = v.imm;
      i_src2_imm = v.simm; i_fwd_sel1 = v.sel1; i_fwd_sel2 = v.sel2;
      i_fwd_mem = v.mem; i_fwd_wb = v.wb; i_cc_we = v.cc_we;
      i_pc = 32'h0000_1000 + 32'(4 * i); i_rds_addr = RADDR_W'(i);
      i_wb_ctrl = WB_W'(i); i_ma_ctrl = MA_W'(i);
      case (v.sel2)
        2'd1:    exp_st = v.mem;
        2'd2:    exp_st = v.wb;
        default: exp_st = v.rs2;
      endcase
      #1;
      chk($sformatf("vec%0d busy", i), 32'(o_busy), 32'd0);
      @(posedge clk); #1;
      chk($sformatf("vec%0d valid", i), 32'(o_valid), 32'd1);
      chk($sformatf("vec%0d rslt", i), o_rslt, v.exp_rslt);
      chk($sformatf("vec%0d cc", i), 32'(o_ccodes), 32'(v.exp_cc));
      chk($sformatf("vec%0d store", i), o_store_data, exp_st);
      chk($sformatf("vec%0d pc", i), o_pc, 32'h0000_1000 + 32'(4 * i));
      chk($sformatf("vec%0d rds", i), 32'(o_rds_addr), 32'(i % 32));
      chk($sformatf("vec%0d ma", i), 32'(o_ma_ctrl), 32'(i % 16));
    end
    i_valid = 1'b0;

    run_mc("mul", OP_MUL, 32'h0001_0000, 32'h0003_0000, 32'd0, 0);
    run_mc("mulhu_stall", OP_MULHU, 32'h0001_0000, 32'h0003_0000, 32'd3, 3);
    run_mc("mul_ones", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 0);
    run_mc("mulhu_ones", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);

`ifdef EX_DIV_EN
    run_mc("divu", OP_DIVU, 32'd100, 32'd7, 32'd14, 0);
    run_mc("remu", OP_REMU, 32'd100, 32'd7, 32'd2, 0);
    run_mc("divu_zero", OP_DIVU, 32'd9, 32'd0, 32'hFFFF_FFFF, 0);
    run_mc("remu_zero", OP_REMU, 32'd9, 32'd0, 32'd9, 0);
`else
    drive(OP_DIVU, 32'd100, 32'd7);
    #1;
    chk("divu_off busy", 32'(o_busy), 32'd0);
    @(posedge clk); #1;
    chk("divu_off valid", 32'(o_valid), 32'd1);
    chk("divu_off rslt", o_rslt, 32'd0);
    i_valid = 1'b0;
`endif

    // Flush in RUN cycle 10 aborts the multiply.
    drive(OP_MUL, 32'd5, 32'd6);
    #1;
    chk("flush accept busy", 32'(o_busy), 32'd1);
    repeat (10) begin @(posedge clk); #1; end
    chk("flush run busy", 32'(o_busy), 32'd1);
    i_flush = 1'b1;
    @(posedge clk); #1;
    i_flush = 1'b0;
    i_valid = 1'b0;
    #1;
    chk("flush busy", 32'(o_busy), 32'd0);
    chk("flush valid", 32'(o_valid), 32'd0);
    drive(OP_SUB, 32'd3, 32'd5);
    #1;
    chk("post_flush busy", 32'(o_busy), 32'd0);
    @(posedge clk); #1;
    chk("post_flush valid", 32'(o_valid), 32'd1);
    chk("post_flush rslt", o_rslt, 32'hFFFF_FFFE);
    chk("post_flush cc", 32'(o_ccodes), 32'h8);
    i_valid = 1'b0;

    // Asynchronous reset in RUN discards the op and clears every output.
    drive(OP_MUL, 32'd7, 32'd9);
    #1;
    repeat (5) begin @(posedge clk); #1; end
    reset = 1'b1;
    i_valid = 1'b0;
    #1;
    chk("rst_run valid", 32'(o_valid), 32'd0);
    chk("rst_run rslt", o_rslt, 32'd0);
    chk("rst_run pc", o_pc, 32'd0);
    chk("rst_run rds", 32'(o_rds_addr), 32'd0);
    chk("rst_run cc", 32'(o_ccodes), 32'd0);
    chk("rst_run busy", 32'(o_busy), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    run_mc("mul_after_rst", OP_MUL, 32'd1000, 32'd3000, 32'd3000000, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_stage_mc.md
# ex_stage_mc

Parametrised execute stage with an iterative multi-cycle multiply/divide engine. It sits between the ID/EX and EX/MA pipeline registers. It selects forwarded operands, executes single-cycle ALU ops in one cycle and MUL/DIV ops over WIDTH cycles, and owns the EX/MA register with stall/flush. While a multi-cycle op runs it raises a stall request upstream and inserts bubbles downstream.

## Interface
Parameters:
- WIDTH, 32: datapath width; must be ≥ 8 and a power of two.
- RADDR_W, 5: register address width.
- WB_W / MA_W, 2 / 4: widths of the pass-through WB and MA control fields.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- i_valid  in  1  ID/EX holds a live instruction.
- i_op  in  4  operation code (see package).
- i_cc_we  in  1  update condition codes.
- i_src2_imm  in  1  op2 = i_imm instead of forwarded rs2.
- i_rs1, i_rs2, i_imm, i_pc  in  WIDTH  operands and PC from ID/EX.
- i_fwd_sel1, i_fwd_sel2  in  2  0 = register, 1 = MEM, 2 = WB, 3 = register.
- i_fwd_mem, i_fwd_wb  in  WIDTH  forwarded data.
- i_rds_addr  in  RADDR_W  destination register.
- i_wb_ctrl / i_ma_ctrl  in  WB_W / MA_W  pass-through control.
- i_stall  in  1  hold EX/MA (downstream stall).
- i_flush  in  1  kill EX/MA contents and abort a running op.
- o_busy  out  1  stall request to IF/ID/EX registers.
- o_valid, o_rslt, o_store_data, o_pc, o_rds_addr, o_wb_ctrl, o_ma_ctrl  out  EX/MA register contents.
- o_ccodes  out  4  registered NZCV.

## Operation
- Ops: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 MUL (low word), 9 MULHU, 10 DIVU, 11 REMU. Codes 12–15 are illegal and produce result 0 in a single cycle.
- Shifts use op2[log2(WIDTH)-1:0].
- o_store_data is always the forwarded rs2, even when i_src2_imm is set.
- Condition codes update only on an accepted single-cycle op with i_cc_we:
  - N = rslt MSB; Z = (rslt == 0).
  - C = carry-out for ADD; for SUB, C = 1 when there is no borrow.
  - V = signed overflow for ADD/SUB; 0 for all other ops.
- FSM states: IDLE, RUN, DONE.
  - IDLE with i_valid and a MUL/DIV op: o_busy = 1 combinationally. At the clock edge, latch forwarded operands, load the counter with WIDTH-1, go to RUN. Operands are latched because forwarding sources change while upstream is stalled.
  - RUN: one bit per cycle. MUL uses shift-add into a 2×WIDTH accumulator; DIV uses restoring division. Go to DONE when the counter reaches 0.
  - DONE: if !i_stall, drop o_busy, load the result into EX/MA, return to IDLE. If i_stall, hold.
- While busy, EX/MA loads a bubble (o_valid = 0) whenever !i_stall.
- Divide by zero: quotient is all ones; remainder is the dividend.
- i_flush takes priority over i_stall. EX/MA.o_valid goes to 0, the FSM goes to IDLE, and CC are not updated.

## Timing
- Single-cycle op: result in EX/MA at the first edge after presentation, with o_busy = 0.
- MUL/DIV: o_busy is high for WIDTH+1 cycles (accept cycle plus WIDTH RUN cycles), then stays high in DONE while i_stall is held. The result is registered at the edge ending DONE, giving latency WIDTH+2 edges.
- o_busy is the only combinational output; all other outputs are registered.
- Reset values: every output 0, FSM IDLE, counter 0, CC 0. Reset asserted mid-RUN discards the operation immediately.
- A simultaneous i_flush and DONE drops the result.

## Configuration
- EX_DIV_EN defined: DIVU and REMU run in the iterative engine.
- EX_DIV_EN undefined: codes 10 and 11 are illegal (single cycle, result 0, no busy), and the divider datapath and DIV sequencing are removed from the engine.

## Structure
- Package ex_pkg holds:
  - op code localparams
  - FSM state enum
  - forward-select encodings
  - helper function is_multicycle(op), which depends on EX_DIV_EN
- One sub-module, ex_muldiv_iter, contains the FSM, counter, accumulator/remainder registers and start/done/abort handshake. The top level holds the operand muxes, ALU, CC register and EX/MA register.

## Test plan
- ADD with i_rs2 = 7 and i_fwd_sel1 = 1 (i_fwd_mem = 100) → o_rslt = 107 next edge, o_busy = 0. SUB 3−5 → 0xFFFFFFFE with NZCV = 1000.
- MUL 0x00010000 × 0x00030000 → o_rslt = 0. MULHU on the same operands → 3. o_busy high exactly 33 cycles; 33 bubble entries precede the result.
- DIVU 100/7 → 14; REMU → 2; DIVU 9/0 → 0xFFFFFFFF; REMU 9/0 → 9. Without EX_DIV_EN: DIVU → 0 in one cycle.
- i_stall held for 3 cycles during DONE → EX/MA unchanged and o_busy high. The result loads on the first cycle after i_stall drops.
- i_flush in RUN cycle 10 → next cycle FSM IDLE, o_busy = 0, o_valid = 0. The following ADD executes normally.
- reset pulse during RUN → all outputs 0 asynchronously; after release, the next MUL completes correctly.
